// File: rtl/dram_bus_master.sv
// dram_bus_master: runs one block read or write on the DRAM bus per accepted request,
// stepping the word address, driving write data and returning the block or a timeout status.
module dram_bus_master #(
    parameter int ADDR_WIDTH        = 16,
    parameter int WORD_WIDTH        = 32,
    parameter int BLOCK_SIZE        = 4,
    parameter int READ_ACCESS_TIME  = 10,
    parameter int WRITE_ACCESS_TIME = 10,
    parameter int CYCLE_TIME        = 2,
    parameter int TIMEOUT           = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_address,
    input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] req_wdata,
    output logic                             resp_valid,
    output logic                             resp_error,
    output logic [BLOCK_SIZE*WORD_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0]            dram_address,
    inout  wire  [WORD_WIDTH-1:0]            dram_data,
    output logic                             dram_read_en,
    output logic                             dram_write_en,
    input  logic                             dram_ack
);
    localparam int IW = BLOCK_SIZE > 1 ? $clog2(BLOCK_SIZE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(READ_ACCESS_TIME + WRITE_ACCESS_TIME + CYCLE_TIME + 1);
    localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RELEASE} state_t;

    state_t                            state;
    logic [TW-1:0]                     t;
    logic [GW-1:0]                     gap;
    logic [IW-1:0]                     idx;
    logic                              done;
    logic [ADDR_WIDTH-1:0]             base;
    logic [BLOCK_SIZE*WORD_WIDTH-1:0]  wdata;
    logic [WORD_WIDTH-1:0]             wword;
    logic                              slot, last, exit_now;

    // gap counts down to the next word boundary; done marks all words handled
    assign slot      = gap == '0 && !done;
    assign last      = idx == IW'(BLOCK_SIZE - 1);
    assign exit_now  = dram_ack || t == TW'(TIMEOUT - 1);
    assign dram_data = state == WRITE ? wword : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_error    <= 1'b0;
            resp_rdata    <= '0;
            dram_read_en  <= 1'b0;
            dram_write_en <= 1'b0;
            dram_address  <= '0;
            t             <= '0;
            gap           <= '0;
            idx           <= '0;
            done          <= 1'b0;
            base          <= '0;
            wdata         <= '0;
            wword         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    base          <= req_address & MASK;
                    dram_address  <= req_address & MASK;
                    wdata         <= req_wdata;
                    wword         <= req_wdata[WORD_WIDTH-1:0];
                    t             <= '0;
                    idx           <= '0;
                    done          <= 1'b0;
                    gap           <= req_write ? GW'(WRITE_ACCESS_TIME - 1) : GW'(READ_ACCESS_TIME - 1);
                    req_ready     <= 1'b0;
                    dram_read_en  <= !req_write;
                    dram_write_en <= req_write;
                    state         <= req_write ? WRITE : READ;
                end
                READ, WRITE: begin
                    t   <= t == TW'(TIMEOUT) ? t : t + 1'b1;
                    gap <= gap == '0 ? GW'(CYCLE_TIME - 1) : gap - 1'b1;
                    if (slot && state == READ)
                        resp_rdata[idx*WORD_WIDTH +: WORD_WIDTH] <= dram_data;
                    if (slot) begin
                        done <= last;
                        idx  <= last ? idx : idx + 1'b1;
                    end
                    // the address stays put on the exit edge so RELEASE shows the last one used
                    if (slot && !last && !exit_now) begin
                        dram_address <= base + ADDR_WIDTH'(idx) + 1'b1;
                        wword        <= wdata[(idx + 1)*WORD_WIDTH +: WORD_WIDTH];
                    end
                    if (exit_now) begin
                        dram_read_en  <= 1'b0;
                        dram_write_en <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_error    <= !dram_ack;
                        state         <= RELEASE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_bus_master.sv
// tb_dram_bus_master: directed block transfers against a timeline model of the bus master
// and a bench-side DRAM responder with slot-only read data.
module tb_dram_bus_master;
    localparam int AW = 16, WW = 32, BS = 4, RAT = 10, WAT = 10, CT = 2, TO = 255;

    logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [BS*WW-1:0] req_wdata = '0;
    logic req_ready, resp_valid, resp_error, dram_read_en, dram_write_en, dram_ack;
    logic [BS*WW-1:0] resp_rdata;
    logic [AW-1:0] dram_address;
    wire  [WW-1:0] dram_data;
    logic [WW-1:0] tb_val;

    dram_bus_master #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS), .READ_ACCESS_TIME(RAT),
        .WRITE_ACCESS_TIME(WAT), .CYCLE_TIME(CT), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .dram_address(dram_address), .dram_data(dram_data), .dram_read_en(dram_read_en),
        .dram_write_en(dram_write_en), .dram_ack(dram_ack));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [BS*WW-1:0] act, input logic [BS*WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_slot(input int t, input int at);
        return t >= at - 1 && (t - (at - 1)) % CT == 0 && (t - (at - 1)) / CT < BS;
    endfunction

    function automatic int kidx(input int t, input int at);
        if (t < at) return 0;
        return ((t - at) / CT + 1 > BS - 1) ? BS - 1 : (t - at) / CT + 1;
    endfunction

    // DRAM responder: data only valid in capture slots, acks at the requested cycle
    logic [WW-1:0] mem [0:255];
    int rt = 0;
    int ack_req = -1;
    int m_ack = -1;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = WW'(i * 3);
        forever begin
            @(posedge clock);
            if (dram_write_en && is_slot(rt, WAT)) mem[dram_address[7:0]] <= dram_data;
            rt <= (dram_read_en || dram_write_en) ? rt + 1 : 0;
        end
    end
    assign tb_val    = !dram_read_en ? 32'h5A5A_5A5A : (is_slot(rt, RAT) ? mem[dram_address[7:0]] : 32'hDEAD_BEEF);
    assign dram_data = dram_write_en ? 'z : tb_val;
    assign dram_ack  = (dram_read_en || dram_write_en) && rt == m_ack;

    // Timeline model: a transaction starts the cycle after acceptance, lasts L enabled cycles,
    // then one release cycle.
    int cyc = 0, s = 0, L = 0, n_acc = 0;
    bit busy = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_base = '0, m_hold = '0, a;
    logic [BS*WW-1:0] m_wd = '0, m_rdata = '0;
    initial forever begin
        @(posedge clock);
        if (reset) begin
            busy = 1'b0;
            m_rdata = '0;
            m_hold = '0;
        end else if (busy) begin
            for (int k = 0; k < BS; k++)
                if (!m_wr && cyc - s < L && cyc - s == RAT - 1 + k * CT) begin
                    a = m_base + AW'(k);
                    m_rdata[k*WW +: WW] = mem[a[7:0]];
                end
            if (cyc - s == L) begin
                busy = 1'b0;
                m_hold = m_base + AW'(kidx(L - 1, m_wr ? WAT : RAT));
            end
        end else if (req_valid) begin
            busy = 1'b1;
            s = cyc + 1;
            m_wr = req_write;
            m_base = req_address & ~AW'(BS - 1);
            m_wd = req_wdata;
            m_ack = ack_req;
            m_err = !(ack_req >= 0 && ack_req < TO);
            L = m_err ? TO : ack_req + 1;
            n_acc++;
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    initial forever begin
        int t, at, k;
        logic e_rd, e_wr, e_rdy, e_v, e_err;
        logic [AW-1:0] e_addr;
        logic [WW-1:0] e_bus;
        @(negedge clock);
        if (chk_on) begin
            t = cyc - s;
            at = m_wr ? WAT : RAT;
            e_rd = 0; e_wr = 0; e_rdy = !busy; e_v = 0; e_err = 0; e_addr = m_hold;
            e_bus = 32'h5A5A_5A5A;
            if (busy && t < L) begin
                k = kidx(t, at);
                e_rd = !m_wr;
                e_wr = m_wr;
                e_addr = m_base + AW'(k);
                a = e_addr;
                e_bus = m_wr ? m_wd[k*WW +: WW] : (is_slot(t, RAT) ? mem[a[7:0]] : 32'hDEAD_BEEF);
            end else if (busy) begin
                e_v = 1;
                e_err = m_err;
                e_addr = m_base + AW'(kidx(L - 1, at));
            end
            chk("read_en", dram_read_en, e_rd);
            chk("write_en", dram_write_en, e_wr);
            chk("req_ready", req_ready, e_rdy);
            chk("resp_valid", resp_valid, e_v);
            chk("resp_error", resp_error, e_err);
            chk("address", dram_address, e_addr);
            chk("bus", dram_data, e_bus);
            chk("rdata", resp_rdata, m_rdata);
        end
    end

    int pulses = 0, errs = 0, rdc = 0, wrc = 0;
    always @(negedge clock) begin
        pulses <= pulses + int'(resp_valid);
        errs   <= errs + int'(resp_error);
        rdc    <= rdc + int'(dram_read_en);
        wrc    <= wrc + int'(dram_write_en);
    end

    int p0, e0, r0, w0;
    task automatic snap();
        p0 = pulses; e0 = errs; r0 = rdc; w0 = wrc;
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [BS*WW-1:0] wd,
                          input int ack, input bit hold);
        int n0 = n_acc;
        bit got = 0;
        req_write = wr; req_address = addr; req_wdata = wd; ack_req = ack; req_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clock); #1;
            got = n_acc != n0;
        end
        chk("accept_in_time", got, 1'b1);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(posedge clock); #1;
            idle = !busy;
        end
        chk("done_in_time", idle, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_rdata", resp_rdata, '0);
        // 1: block read of 0x10, data = addr*3
        snap();
        do_req(0, 16'h0010, '0, 15, 0);
        wait_idle();
        chk("t1_rdata", resp_rdata, {32'h39, 32'h36, 32'h33, 32'h30});
        chk("t1_model_rdata", m_rdata, {32'h39, 32'h36, 32'h33, 32'h30});
        chk("t1_read_cycles", rdc - r0, 16);
        chk("t1_pulses", pulses - p0, 1);
        chk("t1_errors", errs - e0, 0);
        // 2: block write at 0x23 lands on 0x20..0x23
        snap();
        do_req(1, 16'h0023, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 15, 0);
        wait_idle();
        chk("t2_mem", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t2_write_cycles", wrc - w0, 16);
        chk("t2_pulses", pulses - p0, 1);
        chk("t2_errors", errs - e0, 0);
        // 3: no acknowledge -> timeout
        snap();
        do_req(0, 16'h0040, '0, -1, 0);
        wait_idle();
        chk("t3_read_cycles", rdc - r0, 255);
        chk("t3_pulses", pulses - p0, 1);
        chk("t3_errors", errs - e0, 1);
        // 4: read then write with req_valid held
        snap();
        do_req(0, 16'h0020, '0, 15, 1);
        do_req(1, 16'h0030, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 15, 0);
        wait_idle();
        chk("t4_rdata", resp_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t4_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        chk("t4_pulses", pulses - p0, 2);
        // 6: early ack at t=11 keeps words 2..3
        snap();
        do_req(0, 16'h0010, '0, 11, 0);
        wait_idle();
        chk("t6_rdata", resp_rdata, {32'hA3, 32'hA2, 32'h33, 32'h30});
        chk("t6_read_cycles", rdc - r0, 12);
        chk("t6_errors", errs - e0, 0);
        // 5: reset during t=5 of a read
        snap();
        do_req(0, 16'h0010, '0, 15, 0);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("t5_read_en", dram_read_en, 1'b0);
        chk("t5_ready", req_ready, 1'b1);
        chk("t5_rdata", resp_rdata, '0);
        repeat (20) @(posedge clock);
        #1 chk("t5_pulses", pulses - p0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
